// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte producers,
// with packet locking, start-pulse retry on missed handshake, and abort on dropped owners.
module uart_tx_arbiter #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned IDXW        = 2,
    parameter int unsigned ACK_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] data,
    input  logic [NREQ-1:0]   last,
    output logic [NREQ-1:0]   ack,
    output logic              abort,
    output logic [IDXW-1:0]   owner,
    output logic              busy,
    output logic [7:0]        tx_x,
    output logic              tx_start,
    input  logic              tx_ready
);

    localparam int unsigned     CNTW    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(ACK_TIMEOUT - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOAD      = 3'd1;
    localparam logic [2:0] START     = 3'd2;
    localparam logic [2:0] WAIT_LOW  = 3'd3;
    localparam logic [2:0] WAIT_DONE = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [IDXW-1:0] owner_q, owner_d;
    logic [IDXW-1:0] rr_q, rr_d;
    logic            lock_q, lock_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [7:0]      tx_x_q, tx_x_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            abort_q, abort_d;

    logic            win_found;
    logic [IDXW-1:0] win_idx;
    logic [IDXW-1:0] cand;
    logic [IDXW-1:0] owner_inc;

    // Walk upward from the rr pointer, wrapping at NREQ; first active request wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_q;
        cand      = rr_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IDXW'((32'(rr_q) + i) % NREQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign owner_inc = (32'(owner_q) == NREQ - 1) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        lock_d  = lock_q;
        cnt_d   = cnt_q;
        tx_x_d  = tx_x_q;
        ack_d   = '0;
        abort_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_ready && win_found) begin
                    owner_d = win_idx;
                    tx_x_d  = data[{win_idx, 3'b000} +: 8];
                    state_d = LOAD;
                end
            end
            LOAD: state_d = START;
            START: begin
                cnt_d   = '0;
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!tx_ready) begin
                    ack_d[owner_q] = 1'b1;
                    lock_d         = ~last[owner_q];
                    state_d        = WAIT_DONE;
                end else if (cnt_q == CNT_MAX) begin
                    // Transmitter missed the pulse; fire it again without acking.
                    state_d = START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (tx_ready) begin
                    if (lock_q && req[owner_q]) begin
                        tx_x_d  = data[{owner_q, 3'b000} +: 8];
                        state_d = LOAD;
                    end else begin
                        abort_d = lock_q;
                        lock_d  = 1'b0;
                        rr_d    = owner_inc;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            lock_q  <= 1'b0;
            cnt_q   <= '0;
            tx_x_q  <= 8'd0;
            ack_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
            tx_x_q  <= tx_x_d;
            ack_q   <= ack_d;
            abort_q <= abort_d;
        end
    end

    assign ack      = ack_q;
    assign abort    = abort_q;
    assign owner    = owner_q;
    assign busy     = (state_q != IDLE);
    assign tx_x     = tx_x_q;
    assign tx_start = (state_q == START);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed table, hand-written corner sequences and
// randomized packet traffic checked against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ        = 4;
    localparam int unsigned IDXW        = 2;
    localparam int unsigned ACK_TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] data;
    logic [NREQ-1:0]   last;
    logic [NREQ-1:0]   ack;
    logic              abort;
    logic [IDXW-1:0]   owner;
    logic              busy;
    logic [7:0]        tx_x;
    logic              tx_start;
    logic              tx_ready;

    uart_tx_arbiter #(
        .NREQ(NREQ),
        .IDXW(IDXW),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .data(data),
        .last(last),
        .ack(ack),
        .abort(abort),
        .owner(owner),
        .busy(busy),
        .tx_x(tx_x),
        .tx_start(tx_start),
        .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event not seen within cycle budget (required to occur)", name);
    endtask

    // Transmitter model: drops tx_ready after an optional delay, or ignores a start.
    int tx_ignore = 0;
    bit tx_rand = 1'b0;
    bit tx_active = 1'b0;
    int tx_dly = 0;
    int tx_low = 0;

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_active) begin
                if (tx_dly > 0) tx_dly--;
                else if (tx_low > 0) begin
                    tx_ready = 1'b0;
                    tx_low--;
                end else begin
                    tx_ready  = 1'b1;
                    tx_active = 1'b0;
                end
            end else if (tx_start) begin
                if (tx_ignore > 0) tx_ignore--;
                else if (tx_rand && $urandom_range(0, 4) == 0) tx_dly = 0;
                else begin
                    tx_active = 1'b1;
                    tx_dly    = tx_rand ? int'($urandom_range(0, 2)) : 0;
                    tx_low    = tx_rand ? int'($urandom_range(1, 4)) : 3;
                end
            end
        end
    end

    task automatic wait_start(input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_start && n < 64);
        if (!tx_start) fail_timeout(name);
    endtask

    task automatic wait_ack(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack == '0 && n < 64);
        if (ack == '0) fail_timeout(name);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || !tx_ready) && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (busy || !tx_ready) fail_timeout(name);
    endtask

    // Directed single-byte grants; expected winners derived by hand from rr=0 after reset.
    typedef struct {
        logic [NREQ-1:0] req;
        logic [IDXW-1:0] exp_owner;
        logic [7:0]      exp_byte;
    } vec_t;
    vec_t tbl[12];

    task automatic set_vec(input int k, input logic [NREQ-1:0] r, input logic [IDXW-1:0] o);
        tbl[k].req       = r;
        tbl[k].exp_owner = o;
        tbl[k].exp_byte  = 8'(8'h40 + 8 * k + int'(o));
    endtask

    task automatic run_entry(input int k);
        int n;
        @(negedge clk);
        req = tbl[k].req;
        for (int i = 0; i < NREQ; i++) data[8*i +: 8] = 8'(8'h40 + 8 * k + i);
        last = '1;
        wait_start("tbl_start", n);
        check("tbl_latency", 32'(n), 32'd2);
        check("tbl_tx_x", 32'(tx_x), 32'(tbl[k].exp_byte));
        check("tbl_owner", 32'(owner), 32'(tbl[k].exp_owner));
        wait_ack("tbl_ack_wait");
        check("tbl_ack", 32'(ack), 32'd1 << tbl[k].exp_owner);
        req = '0;
        wait_idle("tbl_idle");
    endtask

    // Traffic engine: per-requester queues of {last, byte}; model predicts the byte stream.
    logic [8:0] pq[NREQ][$];
    typedef struct {
        int         idx;
        logic [7:0] b;
    } exp_t;
    exp_t exp_q[$];
    int m_rr = 0;

    task automatic drive_prod();
        for (int i = 0; i < NREQ; i++) begin
            if (pq[i].size() > 0) begin
                req[i]         = 1'b1;
                data[8*i +: 8] = pq[i][0][7:0];
                last[i]        = pq[i][0][8];
            end else begin
                req[i]  = 1'b0;
                last[i] = 1'b0;
            end
        end
    endtask

    // Whole packets are granted in rr order; the pointer moves past each packet's owner.
    task automatic build_model();
        logic [8:0] cp[NREQ][$];
        logic [8:0] it;
        exp_t       e;
        bit         any;
        int         win;
        for (int i = 0; i < NREQ; i++) cp[i] = pq[i];
        do begin
            any = 1'b0;
            win = 0;
            for (int j = 0; j < NREQ; j++) begin
                if (!any && cp[(m_rr + j) % NREQ].size() > 0) begin
                    any = 1'b1;
                    win = (m_rr + j) % NREQ;
                end
            end
            if (any) begin
                do begin
                    it    = cp[win].pop_front();
                    e.idx = win;
                    e.b   = it[7:0];
                    exp_q.push_back(e);
                end while (!it[8] && cp[win].size() > 0);
                m_rr = (win + 1) % NREQ;
            end
        end while (any);
    endtask

    task automatic run_traffic(input string name);
        int budget;
        int c = 0;
        exp_q.delete();
        build_model();
        budget = 40 * exp_q.size() + 64;
        @(negedge clk);
        drive_prod();
        while ((exp_q.size() > 0 || busy) && c < budget) begin
            @(negedge clk);
            c++;
            if (tx_start && exp_q.size() > 0) begin
                check({name, "_tx_x"}, 32'(tx_x), 32'(exp_q[0].b));
                check({name, "_owner"}, 32'(owner), 32'(exp_q[0].idx));
            end
            if (ack != '0) begin
                if (exp_q.size() > 0) begin
                    check({name, "_ack"}, 32'(ack), 32'd1 << exp_q[0].idx);
                    void'(exp_q.pop_front());
                end else begin
                    fail_timeout({name, "_no_extra_ack"});
                end
                for (int i = 0; i < NREQ; i++)
                    if (ack[i] && pq[i].size() > 0) void'(pq[i].pop_front());
                drive_prod();
            end
            if (abort) begin
                vectors++;
                miscompares++;
                $display("FAIL %s_abort: abort=1, required 0", name);
            end
        end
        if (exp_q.size() > 0 || busy) fail_timeout({name, "_drain"});
    endtask

    initial begin
        int n;
        int c1;
        int c2;
        int acks;
        rst  = 1'b1;
        req  = '0;
        data = '0;
        last = '0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_abort", 32'(abort), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_x", 32'(tx_x), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        rst = 1'b1;

        set_vec(0, 4'b0001, 2'd0);
        set_vec(1, 4'b0011, 2'd1);
        set_vec(2, 4'b0011, 2'd0);
        set_vec(3, 4'b1001, 2'd3);
        set_vec(4, 4'b1010, 2'd1);
        set_vec(5, 4'b0110, 2'd2);
        set_vec(6, 4'b0110, 2'd1);
        set_vec(7, 4'b1111, 2'd2);
        set_vec(8, 4'b1111, 2'd3);
        set_vec(9, 4'b1111, 2'd0);
        set_vec(10, 4'b1111, 2'd1);
        set_vec(11, 4'b1000, 2'd3);
        for (int k = 0; k < 12; k++) run_entry(k);

        // Packet lock: requester 0 sends three bytes while requester 2 waits.
        wait_idle("lock_idle");
        m_rr = 0;
        pq[0].push_back(9'h0A1);
        pq[0].push_back(9'h0A2);
        pq[0].push_back(9'h1A3);
        pq[2].push_back(9'h1C2);
        run_traffic("lock");

        // Abort: owner 0 drops req after its first (non-last) byte is acked.
        wait_idle("abort_idle");
        @(negedge clk);
        data = '0;
        data[7:0] = 8'hB1;
        data[15:8] = 8'hD1;
        last = 4'b0010;
        req = 4'b0011;
        wait_start("abort_start", n);
        check("abort_first_tx_x", 32'(tx_x), 32'hB1);
        wait_ack("abort_ack_wait");
        check("abort_first_ack", 32'(ack), 32'b0001);
        req[0] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!abort && n < 32);
        if (!abort) fail_timeout("abort_pulse");
        @(negedge clk);
        check("abort_width", 32'(abort), 32'd0);
        wait_start("abort_next_start", n);
        check("abort_next_tx_x", 32'(tx_x), 32'hD1);
        check("abort_next_owner", 32'(owner), 32'd1);
        wait_ack("abort_next_ack_wait");
        check("abort_next_ack", 32'(ack), 32'b0010);
        req = '0;

        // Start timeout: first pulse ignored, re-pulse ACK_TIMEOUT+1 cycles later.
        wait_idle("to_idle");
        tx_ignore = 1;
        @(negedge clk);
        data[23:16] = 8'hE5;
        last = 4'b0100;
        req = 4'b0100;
        wait_start("to_first", n);
        c1 = cyc;
        check("to_first_tx_x", 32'(tx_x), 32'hE5);
        wait_start("to_second", n);
        c2 = cyc;
        check("to_gap", 32'(c2 - c1), 32'(ACK_TIMEOUT + 1));
        check("to_second_tx_x", 32'(tx_x), 32'hE5);
        acks = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (ack != '0) begin
                acks++;
                check("to_ack", 32'(ack), 32'b0100);
                req = '0;
            end
            if (!busy && acks > 0) break;
        end
        check("to_ack_count", 32'(acks), 32'd1);

        // Reset during WAIT_DONE must clear outputs with no clock edge.
        wait_idle("mrst_idle");
        @(negedge clk);
        data[7:0] = 8'hF0;
        last = 4'b0001;
        req = 4'b0001;
        wait_ack("mrst_ack_wait");
        rst = 1'b0;
        #1;
        check("mrst_tx_start", 32'(tx_start), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_ack", 32'(ack), 32'd0);
        check("mrst_tx_x", 32'(tx_x), 32'd0);
        req = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wait_idle("fair_idle");

        // Fairness after reset: all request continuously, grants start at requester 0.
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) data[8*i +: 8] = 8'(8'h10 + i);
        last = '1;
        req  = '1;
        for (int j = 0; j < 5; j++) begin
            wait_start("fair_start", n);
            check("fair_tx_x", 32'(tx_x), 32'(8'h10 + (j % NREQ)));
        end
        wait_ack("fair_ack_wait");
        req = '0;
        wait_idle("fair_end_idle");

        // Randomized packet traffic against the model.
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        m_rr = 0;
        tx_rand = 1'b1;
        for (int r = 0; r < 12; r++) begin
            wait_idle("rand_idle");
            for (int i = 0; i < NREQ; i++) begin
                pq[i].delete();
                if ($urandom_range(0, 3) != 0) begin
                    int npk = int'($urandom_range(1, 3));
                    for (int p = 0; p < npk; p++) begin
                        int len = int'($urandom_range(1, 4));
                        for (int b = 0; b < len; b++)
                            pq[i].push_back({(b == len - 1), 8'($urandom)});
                    end
                end
            end
            run_traffic("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART transmitter among NREQ byte producers. It selects a requester, loads the byte onto the transmitter, and issues a one-cycle start pulse. It tracks the transmitter's ready handshake and acknowledges the requester once the byte is accepted. Packet locking keeps a multi-byte message from one requester contiguous on the line.

Parameters:
NREQ, 4, number of requesters (2..8).
IDXW, 2, index width; must be at least clog2(NREQ).
ACK_TIMEOUT, 4, cycles to wait for tx_ready to fall after a start pulse before re-issuing start.

Ports:
clk  in  1  system clock; all state updates on its rising edge.
rst  in  1  asynchronous, active-low reset.
req  in  NREQ  per-requester request; bit i is held high while data slice i is valid.
data  in  8*NREQ  bytes; requester i uses bits [8i+7:8i].
last  in  NREQ  bit i is high when requester i's current byte ends its packet.
ack  out  NREQ  one-cycle pulse: requester i's byte was accepted by the transmitter.
abort  out  1  one-cycle pulse: a locked owner dropped req mid-packet.
owner  out  IDXW  index of the current or most recent grant.
busy  out  1  high in every state except IDLE.
tx_x  out  8  byte to the transmitter; registered and stable from LOAD until the next LOAD.
tx_start  out  1  start pulse to the transmitter.
tx_ready  in  1  transmitter idle flag.

Behaviour:
- Reset (rst=0, asynchronous), effective immediately, including mid-frame:
  - state=IDLE; ack=0, abort=0, tx_start=0, busy=0.
  - tx_x=8'd0, owner=0, rr pointer=0, lock=0, timeout counter=0.
- Arbitration:
  - Search starts at the rr pointer and walks upward, wrapping modulo NREQ.
  - The first requester with req high wins.
  - The rr pointer only changes on release, to (owner+1) mod NREQ.
- States:
  - IDLE: when tx_ready=1 and any req bit is high, latch winner into owner, latch its data slice into tx_x, go to LOAD. When tx_ready=0, stay in IDLE.
  - LOAD: one cycle so tx_x settles. Go to START.
  - START: tx_start=1 for exactly this cycle. Clear the timeout counter. Go to WAIT_LOW.
  - WAIT_LOW:
    - On tx_ready=0: pulse ack[owner] for one cycle, set lock = ~last[owner], go to WAIT_DONE.
    - Otherwise increment the counter.
    - When the counter reaches ACK_TIMEOUT-1 with tx_ready still 1: return to START and re-pulse without acking. Retries are unlimited.
  - WAIT_DONE: wait for tx_ready=1, then:
    - lock=1 and req[owner]=1: latch data[owner] into tx_x, go to LOAD. Same owner; other requesters are not considered.
    - lock=1 and req[owner]=0: pulse abort, clear lock, release.
    - lock=0: release.
- Release: rr pointer=(owner+1) mod NREQ, go to IDLE. owner keeps its value.
- Latency: from the IDLE cycle that sees a request, tx_start rises 2 cycles later. The minimum gap between start pulses is byte time plus 3 cycles.
- Requester rules:
  - A requester must hold req and data stable until its ack.
  - req changes by requesters other than owner have no effect while busy.
  - If requester i drops req before its byte is latched in IDLE, no ack is issued. Once latched, the byte is sent.
- Simultaneous requests: resolved purely by the rr pointer, no fixed priority.
- Exactly one ack bit may be high in any cycle.

Test Plan:
- Reset, single requester: hold rst low 3 cycles, then req=4'b0001, data0=8'h77, last0=1. Expect one tx_start pulse with tx_x=8'h77, ack=4'b0001 on the cycle after tx_ready falls, then busy=0 and rr pointer=1.
- Round-robin fairness: req=4'b1111, all last=1, data i=8'h10+i. Expect tx_x order 8'h10, 8'h11, 8'h12, 8'h13, 8'h10.
- Packet lock: req0 sends 3 bytes (8'hA1, 8'hA2, 8'hA3, last on the third) while req2 is asserted throughout. Expect A1, A2, A3 contiguous, then req2's byte; owner=0 across all three.
- Abort: lock active after byte 1, then req0 dropped during WAIT_DONE. Expect a one-cycle abort when tx_ready returns high, then a grant to the next requester.
- Start timeout: transmitter model ignores the first start and keeps tx_ready=1. Expect a second tx_start exactly ACK_TIMEOUT+1 cycles after the first, and a single ack.
- Reset mid-frame: drive rst=0 during WAIT_DONE. Expect tx_start=0, busy=0, ack=0 immediately, with no clock edge. After release, arbitration restarts from requester 0.
